// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: per-channel FSM encoding
// and default parameter values.
package button_debouncer_pkg;

    // Per-channel debounce FSM; the encoding is fixed so waveforms stay readable.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } db_state_e;

    localparam int unsigned DEFAULT_WIDTH         = 2;
    localparam int unsigned DEFAULT_STABLE_CYCLES = 1000000;
    localparam int unsigned DEFAULT_CNT_W         = 20;

endpackage : button_debouncer_pkg

// File: rtl/button_debouncer_if.sv
// Button bundle between the board pins and the debounced consumers.
// The debouncer takes the slave side; the stimulus/board side takes master.
interface button_debouncer_if
    import button_debouncer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] btn_raw;
    logic [WIDTH-1:0] btn_level;
    logic [WIDTH-1:0] btn_press;
    logic [WIDTH-1:0] btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );

endinterface : button_debouncer_if

// File: rtl/button_debouncer_debounce_bit.sv
// One debounce channel: 2-flop synchronizer, 4-state accept FSM with a
// stability counter, and registered level/press/release outputs.
module debounce_bit
    import button_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEFAULT_CNT_W
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    // Count value on which the final stable sample is taken.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic       s1_q;
    logic       s_q;
    db_state_e  state_q;
    db_state_e  state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic       level_q;
    logic       level_d;
    logic       press_q;
    logic       press_d;
    logic       release_q;
    logic       release_d;

    // Synchronizer, FSM state, counter and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q      <= 1'b0;
            s_q       <= 1'b0;
            state_q   <= IDLE_LOW;
            cnt_q     <= CNT_ZERO;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= raw_i;
            s_q       <= s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Next-state, counter and output decode; pulses default low so they last one cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            IDLE_LOW: begin
                if (s_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end

            WAIT_HIGH: begin
                if (!s_q) begin
                    state_d = IDLE_LOW;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = CNT_ZERO;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            IDLE_HIGH: begin
                if (!s_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end

            WAIT_LOW: begin
                if (s_q) begin
                    state_d   = IDLE_HIGH;
                    cnt_d     = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE_LOW;
                    cnt_d     = CNT_ZERO;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE_LOW;
                cnt_d   = CNT_ZERO;
                level_d = 1'b0;
            end
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule : debounce_bit

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: WIDTH independent debounce_bit channels
// on the board clock, no logic shared between channels.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned WIDTH         = DEFAULT_WIDTH,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEFAULT_CNT_W
) (
    input  logic                clk_100Mhz,
    input  logic                reset,
    button_debouncer_if.slave   btn_if
);

    logic [WIDTH-1:0] level_s;
    logic [WIDTH-1:0] press_s;
    logic [WIDTH-1:0] release_s;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_debounce_bit (
            .clk_i     (clk_100Mhz),
            .reset_i   (reset),
            .raw_i     (btn_if.btn_raw[gi]),
            .level_o   (level_s[gi]),
            .press_o   (press_s[gi]),
            .release_o (release_s[gi])
        );
    end

    assign btn_if.btn_level   = level_s;
    assign btn_if.btn_press   = press_s;
    assign btn_if.btn_release = release_s;

endmodule : button_debouncer
